// File: rtl/modn_ones_tracker_if.sv
// modn_ones_tracker_if: beat stream and result handshake for modn_ones_tracker.
// Optional MODN_ONES_CHECK_EN adds the exp_res/mismatch pair.
interface modn_ones_tracker_if #(parameter int WIDTH = 8, parameter int MOD = 2, parameter int BEATS_W = 8);
  localparam int RES_W = $clog2(MOD);
  logic in_valid, in_ready, in_last, res_valid, res_ready, even;
  logic [WIDTH-1:0] in_data;
  logic [RES_W-1:0] res;
  logic [BEATS_W-1:0] frame_beats;
`ifdef MODN_ONES_CHECK_EN
  logic [RES_W-1:0] exp_res;
  logic mismatch;
`endif
  modport master (
    output in_valid, in_data, in_last, res_ready,
`ifdef MODN_ONES_CHECK_EN
    output exp_res, input mismatch,
`endif
    input in_ready, res_valid, res, even, frame_beats
  );
  modport slave (
    input in_valid, in_data, in_last, res_ready,
`ifdef MODN_ONES_CHECK_EN
    input exp_res, output mismatch,
`endif
    output in_ready, res_valid, res, even, frame_beats
  );
endinterface

// File: rtl/modn_ones_tracker.sv
// modn_ones_tracker: per-frame ones count modulo MOD with valid/ready result.
// Optional MODN_ONES_CHECK_EN compares the residue against exp_res sampled on the last beat.
module modn_ones_tracker #(
  parameter int WIDTH   = 8,
  parameter int MOD     = 2,
  parameter int BEATS_W = 8
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  modn_ones_tracker_if.slave bus
);
  localparam int RES_W = $clog2(MOD);
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = RES_W + POP_W;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t r_state;
  logic [RES_W-1:0] r_res;
  logic [BEATS_W-1:0] r_beats;
  logic r_in_ready, r_res_valid;
  logic [POP_W-1:0] w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [RES_W-1:0] w_res_nxt;
  logic [BEATS_W-1:0] w_beats_nxt;
  logic w_accept;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) w_pop = w_pop + POP_W'(bus.in_data[i]);
  end
  assign w_accept = bus.in_valid & r_in_ready;
  // The first beat of a frame starts from zero regardless of the held residue
  assign w_sum = ((r_state == ACCUM) ? SUM_W'(r_res) : SUM_W'(0)) + SUM_W'(w_pop);
  assign w_res_nxt = RES_W'(w_sum % SUM_W'(MOD));
  assign w_beats_nxt = (r_state == IDLE) ? BEATS_W'(1) : (&r_beats ? r_beats : r_beats + BEATS_W'(1));
  assign bus.in_ready = r_in_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res = r_res;
  assign bus.even = (r_res == '0);
  assign bus.frame_beats = r_beats;
`ifdef MODN_ONES_CHECK_EN
  logic r_mismatch;
  assign bus.mismatch = r_mismatch;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_res <= '0;
      r_beats <= '0;
      r_in_ready <= 1'b1;
      r_res_valid <= 1'b0;
`ifdef MODN_ONES_CHECK_EN
      r_mismatch <= 1'b0;
`endif
    end else if (clear || (r_state == DONE && bus.res_ready)) begin
      r_state <= IDLE;
      r_res <= '0;
      r_beats <= '0;
      r_in_ready <= 1'b1;
      r_res_valid <= 1'b0;
`ifdef MODN_ONES_CHECK_EN
      r_mismatch <= 1'b0;
`endif
    end else if (w_accept) begin
      r_res <= w_res_nxt;
      r_beats <= w_beats_nxt;
      r_state <= bus.in_last ? DONE : ACCUM;
      r_in_ready <= ~bus.in_last;
      r_res_valid <= bus.in_last;
`ifdef MODN_ONES_CHECK_EN
      r_mismatch <= bus.in_last & (w_res_nxt != bus.exp_res);
`endif
    end
  end
endmodule

// File: tb/tb_modn_ones_tracker.sv
// tb_modn_ones_tracker: directed checks on three configurations (MOD=2, MOD=3, BEATS_W=2).
module tb_modn_ones_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  modn_ones_tracker_if #(.WIDTH(8), .MOD(2), .BEATS_W(8)) a ();
  modn_ones_tracker_if #(.WIDTH(8), .MOD(3), .BEATS_W(8)) b ();
  modn_ones_tracker_if #(.WIDTH(8), .MOD(2), .BEATS_W(2)) c ();
  modn_ones_tracker #(.WIDTH(8), .MOD(2), .BEATS_W(8)) d2 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(a.slave));
  modn_ones_tracker #(.WIDTH(8), .MOD(3), .BEATS_W(8)) d3 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(b.slave));
  modn_ones_tracker #(.WIDTH(8), .MOD(2), .BEATS_W(2)) db (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(c.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h exp 1", a.in_ready); end
    checks++; if (a.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %0h exp 0", a.res_valid); end
    checks++; if (a.even !== 1'b1) begin errors++; $display("FAIL rst_even got %0h exp 1", a.even); end
    checks++; if (a.frame_beats !== 8'd0) begin errors++; $display("FAIL rst_beats got %0h exp 0", a.frame_beats); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_parity();
    a.in_valid = 1'b1; a.in_data = 8'h01; a.in_last = 1'b0;
    step();
    checks++; if (a.res_valid !== 1'b0) begin errors++; $display("FAIL par_accum_valid got %0h exp 0", a.res_valid); end
    a.in_data = 8'h03; a.in_last = 1'b1;
    step();
    a.in_valid = 1'b0;
    checks++; if (a.res_valid !== 1'b1) begin errors++; $display("FAIL par_valid got %0h exp 1", a.res_valid); end
    checks++; if (a.res !== 1'b1) begin errors++; $display("FAIL par_res got %0h exp 1", a.res); end
    checks++; if (a.even !== 1'b0) begin errors++; $display("FAIL par_even got %0h exp 0", a.even); end
    checks++; if (a.frame_beats !== 8'd2) begin errors++; $display("FAIL par_beats got %0h exp 2", a.frame_beats); end
    a.res_ready = 1'b1;
    step();
    a.res_ready = 1'b0;
    checks++; if (a.res_valid !== 1'b0 || a.res !== 1'b0) begin errors++; $display("FAIL par_idle got valid=%0h res=%0h exp 0/0", a.res_valid, a.res); end
  endtask

  task automatic test_mod3_hold();
    b.in_valid = 1'b1; b.in_last = 1'b0; b.in_data = 8'hFF;
    step();
    step();
    b.in_data = 8'h07; b.in_last = 1'b1;
    step();
    b.in_data = 8'hFF; b.in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (b.res_valid !== 1'b1) begin errors++; $display("FAIL m3_valid[%0d] got %0h exp 1", i, b.res_valid); end
      checks++; if (b.res !== 2'd1) begin errors++; $display("FAIL m3_res[%0d] got %0h exp 1", i, b.res); end
      checks++; if (b.frame_beats !== 8'd3) begin errors++; $display("FAIL m3_beats[%0d] got %0h exp 3", i, b.frame_beats); end
      checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL m3_in_ready[%0d] got %0h exp 0", i, b.in_ready); end
      step();
    end
    b.in_valid = 1'b0; b.res_ready = 1'b1;
    step();
    b.res_ready = 1'b0;
    checks++; if (b.res_valid !== 1'b0 || b.res !== 2'd0 || b.in_ready !== 1'b1) begin errors++; $display("FAIL m3_release got valid=%0h res=%0h rdy=%0h exp 0/0/1", b.res_valid, b.res, b.in_ready); end
  endtask

  task automatic test_back_to_back();
    a.res_ready = 1'b1;
    a.in_valid = 1'b1; a.in_data = 8'h0F; a.in_last = 1'b1;
    step();
    checks++; if (a.res_valid !== 1'b1 || a.res !== 1'b0 || a.even !== 1'b1) begin errors++; $display("FAIL b2b_first got valid=%0h res=%0h even=%0h exp 1/0/1", a.res_valid, a.res, a.even); end
    checks++; if (a.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0h exp 0", a.in_ready); end
    a.in_data = 8'h01;
    step();
    checks++; if (a.in_ready !== 1'b1 || a.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy=%0h valid=%0h exp 1/0", a.in_ready, a.res_valid); end
    step();
    a.in_valid = 1'b0;
    checks++; if (a.res_valid !== 1'b1 || a.res !== 1'b1 || a.frame_beats !== 8'd1) begin errors++; $display("FAIL b2b_second got valid=%0h res=%0h beats=%0h exp 1/1/1", a.res_valid, a.res, a.frame_beats); end
    step();
    a.res_ready = 1'b0;
    checks++; if (a.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0h exp 0", a.res_valid); end
  endtask

  task automatic test_clear();
    a.in_valid = 1'b1; a.in_data = 8'h01; a.in_last = 1'b0;
    repeat (3) step();
    checks++; if (a.res !== 1'b1 || a.frame_beats !== 8'd3) begin errors++; $display("FAIL clr_pre got res=%0h beats=%0h exp 1/3", a.res, a.frame_beats); end
    clear = 1'b1; a.in_last = 1'b1;
    step();
    clear = 1'b0; a.in_valid = 1'b0;
    checks++; if (a.res !== 1'b0 || a.frame_beats !== 8'd0 || a.res_valid !== 1'b0 || a.in_ready !== 1'b1) begin errors++; $display("FAIL clr_post got res=%0h beats=%0h valid=%0h rdy=%0h exp 0/0/0/1", a.res, a.frame_beats, a.res_valid, a.in_ready); end
    a.in_valid = 1'b1; a.in_data = 8'h80; a.in_last = 1'b1;
    step();
    a.in_valid = 1'b0;
    checks++; if (a.res_valid !== 1'b1 || a.res !== 1'b1 || a.frame_beats !== 8'd1) begin errors++; $display("FAIL clr_next got valid=%0h res=%0h beats=%0h exp 1/1/1", a.res_valid, a.res, a.frame_beats); end
    a.res_ready = 1'b1;
    step();
    a.res_ready = 1'b0;
  endtask

  task automatic test_saturate_and_async_reset();
    c.in_valid = 1'b1; c.in_data = 8'h00; c.in_last = 1'b0;
    repeat (3) step();
    checks++; if (c.frame_beats !== 2'd3) begin errors++; $display("FAIL sat_three got %0h exp 3", c.frame_beats); end
    repeat (3) step();
    checks++; if (c.frame_beats !== 2'd3) begin errors++; $display("FAIL sat_six got %0h exp 3", c.frame_beats); end
    c.in_last = 1'b1;
    step();
    c.in_valid = 1'b0;
    checks++; if (c.res_valid !== 1'b1 || c.frame_beats !== 2'd3 || c.res !== 1'b0 || c.even !== 1'b1) begin errors++; $display("FAIL sat_done got valid=%0h beats=%0h res=%0h even=%0h exp 1/3/0/1", c.res_valid, c.frame_beats, c.res, c.even); end
    c.res_ready = 1'b1;
    step();
    c.res_ready = 1'b0;
    c.in_valid = 1'b1; c.in_data = 8'h01; c.in_last = 1'b0;
    step();
    c.in_valid = 1'b0;
    checks++; if (c.res !== 1'b1 || c.frame_beats !== 2'd1) begin errors++; $display("FAIL arst_pre got res=%0h beats=%0h exp 1/1", c.res, c.frame_beats); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (c.res !== 1'b0 || c.even !== 1'b1 || c.in_ready !== 1'b1 || c.res_valid !== 1'b0 || c.frame_beats !== 2'd0) begin errors++; $display("FAIL arst_async got res=%0h even=%0h rdy=%0h valid=%0h beats=%0h exp 0/1/1/0/0", c.res, c.even, c.in_ready, c.res_valid, c.frame_beats); end
    #1 rst_n = 1'b1;
    step();
    c.in_valid = 1'b1; c.in_data = 8'h01; c.in_last = 1'b1;
    step();
    c.in_valid = 1'b0;
    checks++; if (c.res_valid !== 1'b1 || c.res !== 1'b1 || c.frame_beats !== 2'd1) begin errors++; $display("FAIL arst_restart got valid=%0h res=%0h beats=%0h exp 1/1/1", c.res_valid, c.res, c.frame_beats); end
    c.res_ready = 1'b1;
    step();
    c.res_ready = 1'b0;
  endtask

`ifdef MODN_ONES_CHECK_EN
  task automatic test_check();
    a.exp_res = 1'b0;
    a.in_valid = 1'b1; a.in_data = 8'h07; a.in_last = 1'b1;
    step();
    a.in_valid = 1'b0;
    checks++; if (a.res !== 1'b1 || a.mismatch !== 1'b1) begin errors++; $display("FAIL chk_bad got res=%0h mis=%0h exp 1/1", a.res, a.mismatch); end
    a.res_ready = 1'b1;
    step();
    a.res_ready = 1'b0;
    checks++; if (a.mismatch !== 1'b0) begin errors++; $display("FAIL chk_idle got %0h exp 0", a.mismatch); end
    a.in_valid = 1'b1; a.in_data = 8'h03; a.in_last = 1'b1;
    step();
    a.in_valid = 1'b0;
    checks++; if (a.res !== 1'b0 || a.mismatch !== 1'b0) begin errors++; $display("FAIL chk_good got res=%0h mis=%0h exp 0/0", a.res, a.mismatch); end
    a.res_ready = 1'b1;
    step();
    a.res_ready = 1'b0;
  endtask
`endif

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.res_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.res_ready = 1'b0;
    c.in_valid = 1'b0; c.in_data = '0; c.in_last = 1'b0; c.res_ready = 1'b0;
`ifdef MODN_ONES_CHECK_EN
    a.exp_res = '0; b.exp_res = '0; c.exp_res = '0;
`endif
    test_reset();
    test_parity();
    test_mod3_hold();
    test_back_to_back();
    test_clear();
    test_saturate_and_async_reset();
`ifdef MODN_ONES_CHECK_EN
    test_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modn_ones_tracker.md
Name: modn_ones_tracker

Overview:
- Parametrised successor to the team's single-bit even/odd ones FSM.
- Accepts a stream of WIDTH-bit beats grouped into frames and counts the set bits across each frame, modulo MOD.
- Presents the per-frame residue, an even/zero flag and the frame length through a valid/ready result handshake.
- Used by link-check and framing logic in place of the 1-bit parity FSM.

Parameters:
- WIDTH, 8, data beat width in bits (>=1)
- MOD, 2, modulus for the ones count (>=2); MOD=2 gives classic parity
- RES_W, $clog2(MOD), residue width (derived, not overridden)
- BEATS_W, 8, width of the frame beat counter

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: discard the current frame and result
- in_valid  in  1  beat valid
- in_ready  out  1  beat accept
- in_data  in  WIDTH  beat payload
- in_last  in  1  final beat of the frame
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res  out  RES_W  (ones in frame) mod MOD
- even  out  1  1 when res==0
- frame_beats  out  BEATS_W  beats accepted in the frame, saturating

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n).
  - Reset values: state=IDLE, res=0, even=1, res_valid=0, in_ready=1, frame_beats=0.
  - Reset deasserting mid-frame restarts cleanly in IDLE; no partial result survives.
- Definitions:
  - accept = in_valid & in_ready
  - pop = number of 1s in in_data, range 0..WIDTH
- States:
  - IDLE: in_ready=1, res_valid=0.
    - On accept: res <= pop mod MOD, frame_beats <= 1.
    - Go to DONE if in_last, else ACCUM.
  - ACCUM: in_ready=1, res_valid=0.
    - On accept: res <= (res+pop) mod MOD, frame_beats <= sat(frame_beats+1).
    - Go to DONE if in_last.
  - DONE: in_ready=0, res_valid=1.
    - res, even and frame_beats are held stable.
    - On res_ready: go to IDLE, res <= 0, frame_beats <= 0.
- Arithmetic:
  - The intermediate sum res+pop needs RES_W+$clog2(WIDTH+1) bits, since it can reach MOD-1+WIDTH.
  - Reduce with an exact modulo; it must be correct for non-power-of-2 MOD and for WIDTH > MOD.
  - frame_beats saturates at 2^BEATS_W-1; it never wraps.
- Timing:
  - even is combinational from the res register (even == (res==0)).
  - Latency: res_valid rises the cycle after the in_last beat is accepted.
  - Minimum frame spacing is one DONE cycle. A beat presented during DONE is stalled (in_ready=0), not dropped.
  - A single-beat frame (in_last on the first beat) goes IDLE->DONE directly.
- Priority: rst_n > clear > handshakes.
  - clear in any state: go to IDLE, res=0, res_valid=0, frame_beats=0.
  - Any beat or res_ready in that same cycle is ignored, even if in_valid=1.
- in_data and in_last are ignored when in_valid=0.
- in_valid with in_data=0 still counts as a beat: frame_beats increments, res is unchanged.

Optional Feature:
- Macro: MODN_ONES_CHECK_EN.
- When defined, two extra ports are added:
  - exp_res (in, RES_W)
  - mismatch (out, 1)
- exp_res is sampled on the accepted in_last beat.
- In DONE, mismatch = (res != sampled exp_res). It is 0 in all other states and after reset or clear.
- When undefined, neither port exists and there is no added logic; the rest of the behaviour is identical.

Test Plan:
- MOD=2, WIDTH=8, after reset: check in_ready=1, res_valid=0, even=1. Then send frame 0x01,0x03(last) -> next cycle res_valid=1, res=1, even=0, frame_beats=2.
- MOD=3, WIDTH=8, frame 0xFF,0xFF,0x07(last) (pop 8+8+3=19) -> res=1, frame_beats=3. Hold res_ready=0 for 5 cycles -> res_valid, res and frame_beats stable and in_ready=0. Pulse res_ready -> IDLE, res=0.
- Back-to-back: single-beat frame 0x0F(last), then a second frame offered immediately with res_ready tied 1 -> first result res=0 (MOD=2). Second frame's beat stalls exactly one cycle. No beat is lost or double counted.
- clear asserted in ACCUM after 3 beats with in_valid=1 -> next cycle IDLE, res=0, frame_beats=0, res_valid=0. That beat is not counted. A following frame 0x80(last) -> res=1.
- BEATS_W=2: send 6 beats of 0x00 then last -> frame_beats=3 (saturated), res=0, even=1. Assert rst_n low mid-frame -> outputs take reset values asynchronously.
- With MODN_ONES_CHECK_EN, MOD=2: frame 0x07(last) with exp_res=0 -> DONE with res=1, mismatch=1. Frame 0x03(last) with exp_res=0 -> mismatch=0.
